// File: rtl/note_player_pkg.sv
// Shared types and widths for the note player.
// Holds the FSM state encoding and the phase/step helper.
package note_player_pkg;

    localparam int NOTE_W    = 6;
    localparam int DUR_W     = 6;
    localparam int STEP_W    = 20;
    localparam int PHASE_W   = 22;
    localparam int ROM_DEPTH = 1 << NOTE_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PLAYING = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef logic [NOTE_W-1:0]  note_t;
    typedef logic [DUR_W-1:0]   dur_t;
    typedef logic [STEP_W-1:0]  step_t;
    typedef logic [PHASE_W-1:0] phase_t;

    // Phase advance wraps modulo 2^PHASE_W by truncation.
    function automatic phase_t phase_add(
        input phase_t p,
        input step_t  s
    );
        return p + PHASE_W'(s);
    endfunction

endpackage

// File: rtl/frequency_rom.sv
// 64 x 20 phase-increment ROM, one-cycle registered read.
// Ports: clk, reset (async, high), en (read strobe), clr (zero the
// output), addr (note index), data (phase increment for that note).
module frequency_rom
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [NOTE_W-1:0] addr,
    output logic [STEP_W-1:0] data
);

    // Entry k = round(440 * 2^((k-49)/12) * 2^22 / 48000); entry 0 is a rest.
    localparam logic [STEP_W-1:0] TABLE [ROM_DEPTH] = '{
        20'd0,
        20'd2403,  20'd2546,  20'd2697,  20'd2858,
        20'd3028,  20'd3208,  20'd3398,  20'd3600,
        20'd3815,  20'd4041,  20'd4282,  20'd4536,
        20'd4806,  20'd5092,  20'd5395,  20'd5715,
        20'd6055,  20'd6415,  20'd6797,  20'd7201,
        20'd7629,  20'd8083,  20'd8563,  20'd9072,
        20'd9612,  20'd10184, 20'd10789, 20'd11431,
        20'd12110, 20'd12830, 20'd13593, 20'd14402,
        20'd15258, 20'd16165, 20'd17127, 20'd18145,
        20'd19224, 20'd20367, 20'd21578, 20'd22861,
        20'd24221, 20'd25661, 20'd27187, 20'd28803,
        20'd30516, 20'd32331, 20'd34253, 20'd36290,
        20'd38448, 20'd40734, 20'd43156, 20'd45722,
        20'd48441, 20'd51322, 20'd54373, 20'd57607,
        20'd61032, 20'd64661, 20'd68506, 20'd72580,
        20'd76896, 20'd81468, 20'd86312
    };

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (clr) begin
            data <= '0;
        end else if (en) begin
            data <= TABLE[addr];
        end
    end

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: looks up its phase step, counts beats,
// runs the phase accumulator, and pulses note_done when finished.
// Ports: clk, reset (async, high), play (0 = freeze), new_note strobe
// with note/duration, beat and generate_next_sample strobes;
// outputs note_done, note_active, freq_step, phase.
// Option: define NOTE_PLAYER_GAP_EN to silence the final beat of
// each note (articulation gap); note_done timing is unaffected.
module note_player
    import note_player_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               new_note,
    input  logic [NOTE_W-1:0]  note,
    input  logic [DUR_W-1:0]   duration,
    input  logic               beat,
    input  logic               generate_next_sample,
    output logic               note_done,
    output logic               note_active,
    output logic [STEP_W-1:0]  freq_step,
    output logic [PHASE_W-1:0] phase
);

    state_t state;
    note_t  note_q;
    dur_t   dur_q;
    dur_t   remaining;

    logic rom_en;
    logic rom_clr;
    logic audible;
    logic load_snd;
    logic beat_snd;
    logic advance;

    // ROM is read during LOAD so the step is valid on entry to PLAYING
    // (or DONE for zero-length notes); cleared as DONE falls back to IDLE.
    assign rom_en  = (state == ST_LOAD);
    assign rom_clr = (state == ST_DONE) && !new_note;
    assign audible = (note_q != '0);

`ifdef NOTE_PLAYER_GAP_EN
    // Quiet while the last beat is pending: remaining <= 1.
    assign load_snd = audible && (dur_q > DUR_W'(1));
    assign beat_snd = audible && (remaining > DUR_W'(2));
    assign advance  = generate_next_sample &&
                      (remaining != DUR_W'(1));
`else
    assign load_snd = audible;
    assign beat_snd = audible;
    assign advance  = generate_next_sample;
`endif

    frequency_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .en    (rom_en),
        .clr   (rom_clr),
        .addr  (note_q),
        .data  (freq_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            note_q      <= '0;
            dur_q       <= '0;
            remaining   <= '0;
            phase       <= '0;
            note_done   <= 1'b0;
            note_active <= 1'b0;
        end else begin
            note_done <= 1'b0;
            // A new note preempts whatever is in flight, silently.
            if (new_note) begin
                state       <= ST_LOAD;
                note_q      <= note;
                dur_q       <= duration;
                note_active <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_LOAD: begin
                        remaining <= dur_q;
                        if (dur_q == '0) begin
                            state     <= ST_DONE;
                            note_done <= 1'b1;
                        end else begin
                            state       <= ST_PLAYING;
                            note_active <= load_snd;
                        end
                    end
                    ST_PLAYING: begin
                        // Count reached zero on the previous beat.
                        if (remaining == '0) begin
                            state       <= ST_DONE;
                            note_done   <= 1'b1;
                            note_active <= 1'b0;
                        end else if (play) begin
                            if (beat) begin
                                remaining   <= remaining - DUR_W'(1);
                                note_active <= beat_snd;
                            end
                            if (advance) begin
                                phase <= phase_add(phase, freq_step);
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: stimulus queues expected
// note_done events and level samples; a negedge monitor checks them.
module tb_note_player;
    import note_player_pkg::*;

`ifdef NOTE_PLAYER_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               play;
    logic               new_note;
    logic [NOTE_W-1:0]  note;
    logic [DUR_W-1:0]   duration;
    logic               beat;
    logic               generate_next_sample;
    logic               note_done;
    logic               note_active;
    logic [STEP_W-1:0]  freq_step;
    logic [PHASE_W-1:0] phase;

    note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play                 (play),
        .new_note             (new_note),
        .note                 (note),
        .duration             (duration),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .note_done            (note_done),
        .note_active          (note_active),
        .freq_step            (freq_step),
        .phase                (phase)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {K_ACT, K_STEP, K_PHASE} kind_t;
    typedef struct {
        int          at;
        kind_t       kind;
        logic [31:0] val;
    } lvl_t;
    typedef struct {
        int at;
        int step;
    } done_t;

    lvl_t  lvl_q[$];
    done_t done_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sample(input kind_t k);
        case (k)
            K_ACT:   return 32'(note_active);
            K_STEP:  return 32'(freq_step);
            default: return 32'(phase);
        endcase
    endfunction

    function automatic string kname(input kind_t k);
        case (k)
            K_ACT:   return "note_active";
            K_STEP:  return "freq_step";
            default: return "phase";
        endcase
    endfunction

    // Monitor: level samples due this cycle, and note_done events.
    always @(negedge clk) begin
        done_t d;
        for (int i = lvl_q.size() - 1; i >= 0; i--) begin
            if (lvl_q[i].at < cyc) begin
                chk("stale_level_check", cyc, lvl_q[i].at);
                lvl_q.delete(i);
            end else if (lvl_q[i].at == cyc) begin
                chk(kname(lvl_q[i].kind), sample(lvl_q[i].kind),
                    lvl_q[i].val);
                lvl_q.delete(i);
            end
        end
        if (note_done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("note_done_unexpected", 32'(note_done), 0);
            end else begin
                d = done_q.pop_front();
                chk("note_done_cycle", cyc, d.at);
                chk("note_done_step", 32'(freq_step), d.step);
            end
        end else if (note_done !== 1'b0) begin
            chk("note_done_known", 32'(note_done), 0);
        end else if (done_q.size() != 0 && done_q[0].at < cyc) begin
            d = done_q.pop_front();
            chk("note_done_missing_by", cyc, d.at);
        end
    end

    task automatic step(input int nn, input int nt, input int du,
                        input int b, input int g, input int p);
        @(negedge clk);
        new_note             = 1'(nn);
        note                 = 6'(nt);
        duration             = 6'(du);
        beat                 = 1'(b);
        generate_next_sample = 1'(g);
        play                 = 1'(p);
    endtask

    task automatic idle(input int n, input int p);
        repeat (n) step(0, 0, 0, 0, 0, p);
    endtask

    task automatic expect_lvl(input kind_t k, input int dt, input int v);
        lvl_q.push_back('{at: cyc + dt, kind: k, val: v});
    endtask

    task automatic expect_done(input int dt, input int st);
        done_q.push_back('{at: cyc + dt, step: st});
    endtask

    task automatic do_reset();
        idle(4, 1);
        @(negedge clk);
        reset = 1'b1;
        new_note = 1'b0;
        beat = 1'b0;
        generate_next_sample = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        play = 1'b0;
        new_note = 1'b0;
        note = '0;
        duration = '0;
        beat = 1'b0;
        generate_next_sample = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_note_done", 32'(note_done), 0);
        chk("rst_note_active", 32'(note_active), 0);
        chk("rst_freq_step", 32'(freq_step), 0);
        chk("rst_phase", 32'(phase), 0);
        @(negedge clk);
        reset = 1'b0;

        // A4 for three beats, beat every 10 cycles
        do_reset();
        step(1, 49, 3, 0, 0, 1);
        expect_lvl(K_STEP, 2, 38448);
        expect_lvl(K_ACT, 2, 1);
        idle(9, 1);
        step(0, 0, 0, 1, 0, 1);
        expect_lvl(K_ACT, 1, 1);
        idle(9, 1);
        step(0, 0, 0, 1, 0, 1);
        expect_lvl(K_ACT, 1, GAP ? 0 : 1);
        idle(9, 1);
        step(0, 0, 0, 1, 0, 1);
        expect_done(2, 38448);
        expect_lvl(K_ACT, 2, 0);
        expect_lvl(K_STEP, 3, 0);

        // Phase accumulation and wrap
        do_reset();
        step(1, 49, 2, 0, 0, 1);
        idle(1, 1);
        repeat (100) step(0, 0, 0, 0, 1, 1);
        expect_lvl(K_PHASE, 1, 3844800);
        repeat (10) step(0, 0, 0, 0, 1, 1);
        expect_lvl(K_PHASE, 1, 34976);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        expect_done(2, 38448);
        expect_lvl(K_PHASE, 2, 34976);

        // Pause freezes beat count and phase
        do_reset();
        step(1, 1, 4, 0, 0, 1);
        idle(1, 1);
        repeat (3) step(0, 0, 0, 0, 1, 1);
        expect_lvl(K_PHASE, 1, 7209);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0, (i % 5 == 0) ? 1 : 0, 1, 0);
        end
        expect_lvl(K_PHASE, 1, 7209);
        expect_lvl(K_STEP, 1, 2403);
        expect_lvl(K_ACT, 1, 1);
        step(0, 0, 0, 1, 0, 1);
        idle(2, 1);
        step(0, 0, 0, 1, 0, 1);
        expect_done(2, 2403);

        // Zero-length notes, top ROM entry, and a rest
        do_reset();
        step(1, 5, 0, 0, 0, 1);
        expect_done(2, 3028);
        expect_lvl(K_ACT, 2, 0);
        idle(4, 1);
        step(1, 63, 0, 0, 0, 1);
        expect_done(2, 86312);
        idle(4, 1);
        step(1, 0, 2, 0, 0, 1);
        expect_lvl(K_STEP, 2, 0);
        expect_lvl(K_ACT, 2, 0);
        idle(3, 1);
        step(0, 0, 0, 1, 0, 1);
        idle(3, 1);
        step(0, 0, 0, 1, 0, 1);
        expect_done(2, 0);

        // New note coincident with the final beat
        do_reset();
        step(1, 49, 2, 0, 0, 1);
        idle(3, 1);
        step(0, 0, 0, 1, 0, 1);
        idle(3, 1);
        step(1, 37, 1, 1, 0, 1);
        expect_lvl(K_STEP, 2, 19224);
        idle(3, 1);
        step(0, 0, 0, 1, 0, 1);
        expect_done(2, 19224);

        // Asynchronous reset mid-note
        do_reset();
        step(1, 49, 3, 0, 0, 1);
        idle(1, 1);
        repeat (5) step(0, 0, 0, 0, 1, 1);
        expect_lvl(K_PHASE, 1, 192240);
        step(0, 0, 0, 1, 0, 1);
        idle(2, 1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_note_active", 32'(note_active), 0);
        chk("arst_freq_step", 32'(freq_step), 0);
        chk("arst_phase", 32'(phase), 0);
        chk("arst_note_done", 32'(note_done), 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, (i % 4 == 0) ? 1 : 0, 1, 1);
        end
        expect_lvl(K_PHASE, 1, 0);
        expect_lvl(K_STEP, 1, 0);

        // Final-beat interval: gap build silences and holds phase
        do_reset();
        step(1, 49, 2, 0, 0, 1);
        idle(1, 1);
        step(0, 0, 0, 0, 1, 1);
        expect_lvl(K_PHASE, 1, 38448);
        expect_lvl(K_ACT, 1, 1);
        step(0, 0, 0, 1, 0, 1);
        expect_lvl(K_ACT, 1, GAP ? 0 : 1);
        step(0, 0, 0, 0, 1, 1);
        expect_lvl(K_PHASE, 1, GAP ? 38448 : 76896);
        idle(2, 1);
        step(0, 0, 0, 1, 0, 1);
        expect_done(2, 38448);

        idle(6, 1);
        chk("done_queue_drained", done_q.size(), 0);
        chk("level_queue_drained", lvl_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
